// File: rtl/pll_reset_seq.sv
// Lock-qualified staged reset sequencer: peripherals leave reset first, NES core second.
// Optional lock-loss event counter is built when PLL_RESET_SEQ_LOSS_COUNT_EN is defined.
module pll_reset_seq #(
    parameter int LOCK_STABLE = 1024,
    parameter int RESET_HOLD  = 16,
    parameter int STAGGER     = 4,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       periph_reset,
    output logic       core_reset,
    output logic       ready,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        PERIPH    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);

    logic             lock_meta_q;
    logic             lock_s_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             periph_reset_q, periph_reset_d;
    logic             core_reset_q, core_reset_d;
    logic             ready_q, ready_d;
    logic             lock_lost;

    // Two-flop synchroniser; cleared by reset so lock is re-qualified from scratch.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    assign lock_lost = (state_q != WAIT_LOCK) && !lock_s_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= WAIT_LOCK;
            cnt_q          <= '0;
            periph_reset_q <= 1'b1;
            core_reset_q   <= 1'b1;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            periph_reset_q <= periph_reset_d;
            core_reset_q   <= core_reset_d;
            ready_q        <= ready_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        periph_reset_d = periph_reset_q;
        core_reset_d   = core_reset_q;
        ready_d        = ready_q;

        // Lock loss outranks every count-based transition.
        if (lock_lost) begin
            state_d        = WAIT_LOCK;
            cnt_d          = '0;
            periph_reset_d = 1'b1;
            core_reset_d   = 1'b1;
            ready_d        = 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    periph_reset_d = 1'b1;
                    core_reset_d   = 1'b1;
                    ready_d        = 1'b0;
                    if (!lock_s_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d        = PERIPH;
                        cnt_d          = '0;
                        periph_reset_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PERIPH: begin
                    if (cnt_q == STAGGER_LAST) begin
                        state_d      = RUN;
                        cnt_d        = '0;
                        core_reset_d = 1'b0;
                        ready_d      = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign periph_reset = periph_reset_q;
    assign core_reset   = core_reset_q;
    assign ready        = ready_q;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    // Saturating count of lock losses after qualification.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lock_lost && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            loss_cnt_q <= 8'd0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with LOCK_STABLE=8, RESET_HOLD=4, STAGGER=2.
// Loss-count expectations follow PLL_RESET_SEQ_LOSS_COUNT_EN.
module tb_pll_reset_seq;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       pll_lock;
    logic       periph_reset;
    logic       core_reset;
    logic       ready;
    logic [7:0] lock_loss_cnt;

    int checkCount = 0;
    int passCount  = 0;

    pll_reset_seq #(
        .LOCK_STABLE(8),
        .RESET_HOLD (4),
        .STAGGER    (2),
        .CNT_W      (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .periph_reset (periph_reset),
        .core_reset   (core_reset),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic l);
        reset    = r;
        pll_lock = l;
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic checkAll(input string tag, input logic p, input logic c, input logic r, input logic [7:0] l);
        checkOutput({tag, "_periph"}, {7'd0, periph_reset}, {7'd0, p});
        checkOutput({tag, "_core"},   {7'd0, core_reset},   {7'd0, c});
        checkOutput({tag, "_ready"},  {7'd0, ready},        {7'd0, r});
        checkOutput({tag, "_loss"},   lock_loss_cnt,        l);
    endtask

    // Edge 0 is the final reset edge, which already samples pll_lock=1.
    task automatic resetWithLock();
        applyStimulus(1'b1, 1'b0);
        tick(2);
        applyStimulus(1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b1);
    endtask

    // Ordering invariants sampled on the falling edge throughout the run.
    always @(negedge clk) begin
        checkOutput("inv_ready", {7'd0, ready & (periph_reset | core_reset)}, 8'd0);
        checkOutput("inv_order", {7'd0, ~core_reset & periph_reset}, 8'd0);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b1, 1'b0);

        // Clean start: HOLD at 10, periph release at 14, core release and ready at 16.
        tick(4);
        applyStimulus(1'b1, 1'b1);
        tick(1);
        checkAll("t1_reset", 1'b1, 1'b1, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b1);
        tick(13);
        checkAll("t1_e13", 1'b1, 1'b1, 1'b0, 8'd0);
        tick(1);
        checkAll("t1_e14", 1'b0, 1'b1, 1'b0, 8'd0);
        tick(1);
        checkAll("t1_e15", 1'b0, 1'b1, 1'b0, 8'd0);
        tick(1);
        checkAll("t1_e16", 1'b0, 1'b0, 1'b1, 8'd0);

        // Loss in RUN: dropped lock sampled at edge 17 takes effect at edge 19.
        applyStimulus(1'b0, 1'b0);
        tick(2);
        checkAll("t3_e18", 1'b0, 1'b0, 1'b1, 8'd0);
        tick(1);
        checkAll("t3_e19", 1'b1, 1'b1, 1'b0, LOSS_EN ? 8'd1 : 8'd0);
        applyStimulus(1'b0, 1'b1);
        tick(13);
        checkAll("t3_e32", 1'b1, 1'b1, 1'b0, LOSS_EN ? 8'd1 : 8'd0);
        tick(1);
        checkAll("t3_e33", 1'b0, 1'b1, 1'b0, LOSS_EN ? 8'd1 : 8'd0);
        tick(1);
        checkAll("t3_e34", 1'b0, 1'b1, 1'b0, LOSS_EN ? 8'd1 : 8'd0);
        tick(1);
        checkAll("t3_e35", 1'b0, 1'b0, 1'b1, LOSS_EN ? 8'd1 : 8'd0);

        // Reset pulse in RUN: everything back to reset values, sequence restarts.
        applyStimulus(1'b1, 1'b1);
        tick(1);
        checkAll("t5_reset", 1'b1, 1'b1, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b1);
        tick(13);
        checkAll("t5_e13", 1'b1, 1'b1, 1'b0, 8'd0);
        tick(1);
        checkAll("t5_e14", 1'b0, 1'b1, 1'b0, 8'd0);
        tick(1);
        checkAll("t5_e15", 1'b0, 1'b1, 1'b0, 8'd0);
        tick(1);
        checkAll("t5_e16", 1'b0, 1'b0, 1'b1, 8'd0);

        // Loss in PERIPH: lock_s low on the second PERIPH cycle (edge 16).
        resetWithLock();
        tick(13);
        applyStimulus(1'b0, 1'b0);
        tick(1);
        checkAll("t4_e14", 1'b0, 1'b1, 1'b0, 8'd0);
        tick(1);
        checkAll("t4_e15", 1'b0, 1'b1, 1'b0, 8'd0);
        tick(1);
        checkAll("t4_e16", 1'b1, 1'b1, 1'b0, LOSS_EN ? 8'd1 : 8'd0);
        tick(6);
        checkAll("t4_e22", 1'b1, 1'b1, 1'b0, LOSS_EN ? 8'd1 : 8'd0);

        // Glitch in WAIT_LOCK at edge 5: lock_s back high after 7, HOLD at 15, ready at 21.
        resetWithLock();
        tick(4);
        applyStimulus(1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b1);
        tick(9);
        checkAll("t2_e14", 1'b1, 1'b1, 1'b0, 8'd0);
        tick(4);
        checkAll("t2_e18", 1'b1, 1'b1, 1'b0, 8'd0);
        tick(1);
        checkAll("t2_e19", 1'b0, 1'b1, 1'b0, 8'd0);
        tick(1);
        checkAll("t2_e20", 1'b0, 1'b1, 1'b0, 8'd0);
        tick(1);
        checkAll("t2_e21", 1'b0, 1'b0, 1'b1, 8'd0);

        // Saturation: each iteration qualifies lock, reaches PERIPH, then loses lock once.
        resetWithLock();
        applyStimulus(1'b0, 1'b0);
        tick(4);
        checkAll("t6_start", 1'b1, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b1);
            tick(12);
            applyStimulus(1'b0, 1'b0);
            tick(4);
            if (i == 0)   checkOutput("t6_first", lock_loss_cnt, LOSS_EN ? 8'd1 : 8'd0);
            if (i == 253) checkOutput("t6_254",   lock_loss_cnt, LOSS_EN ? 8'd254 : 8'd0);
            if (i == 254) checkOutput("t6_255",   lock_loss_cnt, LOSS_EN ? 8'd255 : 8'd0);
        end
        checkAll("t6_end", 1'b1, 1'b1, 1'b0, LOSS_EN ? 8'd255 : 8'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
